// File: rtl/serial_frame_rx_if.sv
// Byte-wide valid/ready stream carried out of serial_frame_rx.
// master: the receiver, which sources head-of-FIFO bytes.
// slave : the byte-wide consumer, which returns data_ready.
interface serial_frame_rx_if;
    logic [7:0] data_out;
    logic       data_last;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;

    modport master (
        output data_out,
        output data_last,
        output data_valid,
        output parity_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_last,
        input  data_valid,
        input  parity_err,
        output data_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver.
// - Hunts the qualified bit stream for SYNC_PATTERN.
// - Assembles the next FRAME_LEN bytes MSB-first.
// - Queues them in a first-word fall-through FIFO that drains over a valid/ready byte interface.
// Optional feature: define SERIAL_FRAME_RX_PARITY_EN to expect an even-parity bit after every
// payload byte. A bad parity bit is flagged on parity_err and does not abort the frame.
module serial_frame_rx #(
    parameter logic [7:0] SYNC_PATTERN = 8'hA5,
    parameter int         FRAME_LEN    = 4,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   ovf_clr,
    output logic                   locked,
    output logic                   overflow,
    serial_frame_rx_if.master      byte_if
);

    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {HUNT, DATA} state_t;
`endif

    typedef struct packed {
        logic       last;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    state_t               state_q;
    logic                 locked_q;
    logic [7:0]           sh_q;
    logic [7:0]           sh_d;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           byte_cnt_q;

    entry_t               mem_q [FIFO_DEPTH];
    entry_t               head;
    entry_t               push_entry;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;

    logic                 fifo_valid;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 wr_en;

    assign fifo_valid = (count_q != '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = fifo_valid && byte_if.data_ready;
    assign drop       = push && full && !pop;
    assign wr_en      = push && !drop;
    assign head       = mem_q[rd_ptr_q];

    // Decide whether this cycle completes a payload byte, and what gets queued for it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sh_d            = {sh_q[6:0], bit_in};
        push            = 1'b0;
        push_entry.last = (byte_cnt_q == LAST_IDX);
        push_entry.perr = 1'b0;
        push_entry.data = sh_d;
        if (bit_valid) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            // The byte is already whole in sh_q; bit_in is its parity bit.
            if (state_q == PARITY) begin
                push            = 1'b1;
                push_entry.data = sh_q;
                push_entry.perr = ^{sh_q, bit_in};
            end
`else
            if (state_q == DATA && bit_cnt_q == 3'd7) begin
                push = 1'b1;
            end
`endif
        end
    end

    // Frame FSM: sync hunt, bit/byte counting, and the registered locked flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else if (bit_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values, whatever order these statements appear in.
            sh_q <= sh_d;
            case (state_q)
                HUNT: begin
                    if (sh_d == SYNC_PATTERN) begin
                        state_q    <= DATA;
                        locked_q   <= 1'b1;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                DATA: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= PARITY;
                    end
`endif
                end
                default: ;
            endcase
            // A finished byte either ends the frame (last byte or FIFO overflow) or continues it.
            if (push) begin
                if (drop || push_entry.last) begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end else begin
                    state_q    <= DATA;
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    // FIFO storage; entries are only ever read while counted valid.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; outputs are gated by fifo_valid, so stale entries never leak.
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Sticky overflow flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign locked             = locked_q;
    assign overflow           = overflow_q;
    assign byte_if.data_valid = fifo_valid;
    assign byte_if.data_out   = fifo_valid ? head.data : 8'h00;
    assign byte_if.data_last  = fifo_valid & head.last;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign byte_if.parity_err = fifo_valid & head.perr;
`else
    assign byte_if.parity_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{sh_q[7], head.perr};
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx. A queue-based frame model is checked against the DUT
// on every negedge, and literal expectations on the delivered bytes pin down the model.
// With SERIAL_FRAME_RX_PARITY_EN defined, payload bytes carry a parity bit and a parity section runs.
module tb_serial_frame_rx;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         FRAME_LEN = 4;
    localparam int         DEPTH     = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int         BITS_PER  = 9;
`else
    localparam int         BITS_PER  = 8;
`endif

    logic clk;
    logic reset;
    logic bit_valid;
    logic bit_in;
    logic ovf_clr;
    logic locked;
    logic overflow;

    serial_frame_rx_if byte_if ();

    serial_frame_rx #(
        .SYNC_PATTERN (SYNC),
        .FRAME_LEN    (FRAME_LEN),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .ovf_clr   (ovf_clr),
        .locked    (locked),
        .overflow  (overflow),
        .byte_if   (byte_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         perr;
    } ent_t;

    int unsigned m_win;
    bit          m_locked;
    bit          m_bits[$];
    int          m_nbytes;
    ent_t        m_fifo[$];
    bit          m_ovf;

    always @(posedge clk or negedge reset) begin
        bit   pop_m;
        bit   push_m;
        bit   drop_m;
        ent_t e;
        if (!reset) begin
            m_win    = 0;
            m_locked = 0;
            m_bits.delete();
            m_nbytes = 0;
            m_fifo.delete();
            m_ovf    = 0;
        end else begin
            pop_m  = (m_fifo.size() > 0) && byte_if.data_ready;
            push_m = 0;
            e      = '{b: 8'h00, last: 0, perr: 0};
            if (bit_valid) begin
                m_win = ((m_win << 1) | int'(bit_in)) & 32'hFF;
                if (!m_locked) begin
                    if (m_win == SYNC) begin
                        m_locked = 1;
                        m_nbytes = 0;
                        m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == BITS_PER) begin
                        for (int i = 0; i < 8; i++) e.b = {e.b[6:0], m_bits[i]};
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        e.perr = (^e.b) ^ m_bits[8];
`endif
                        m_nbytes++;
                        e.last = (m_nbytes == FRAME_LEN);
                        m_bits.delete();
                        push_m = 1;
                        if (e.last) m_locked = 0;
                    end
                end
            end
            drop_m = push_m && (m_fifo.size() == DEPTH) && !pop_m;
            if (pop_m) void'(m_fifo.pop_front());
            if (push_m && !drop_m) m_fifo.push_back(e);
            if (drop_m) begin
                m_ovf    = 1;
                m_locked = 0;
            end else if (ovf_clr) begin
                m_ovf = 0;
            end
        end
    end

    // ---------------- per-cycle compare and delivery capture ----------------
    ent_t got_q[$];

    always @(negedge clk) begin
        check("data_valid", byte_if.data_valid, m_fifo.size() != 0);
        check("locked", locked, m_locked);
        check("overflow", overflow, m_ovf);
        if (m_fifo.size() != 0) begin
            check("data_out", byte_if.data_out, m_fifo[0].b);
            check("data_last", byte_if.data_last, m_fifo[0].last);
            check("parity_err", byte_if.parity_err, m_fifo[0].perr);
        end
        if (byte_if.data_valid === 1'b1 && byte_if.data_ready === 1'b1) begin
            got_q.push_back('{b: byte_if.data_out, last: byte_if.data_last, perr: byte_if.parity_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b, input bit gap);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        if (gap) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    // Payload byte, followed by its correct even-parity bit when parity is enabled.
    task automatic send_payload(input logic [7:0] v, input bit gap);
        send_byte(v, gap);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit(^v, gap);
`endif
    endtask

    // Expected bytes are written left to right: first delivered byte in the top bits.
    task automatic check_frame(input string name, input int n, input logic [63:0] bytes,
                               input logic [7:0] lasts, input logic [7:0] perrs);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_byte%0d", name, i), got_q[i].b, bytes[(n-1-i)*8 +: 8]);
                check($sformatf("%s_last%0d", name, i), got_q[i].last, lasts[n-1-i]);
                check($sformatf("%s_perr%0d", name, i), got_q[i].perr, perrs[n-1-i]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, byte_if.data_valid, 1'b0);
        check({name, "_data"}, byte_if.data_out, 8'h00);
        check({name, "_last"}, byte_if.data_last, 1'b0);
        check({name, "_perr"}, byte_if.parity_err, 1'b0);
        check({name, "_locked"}, locked, 1'b0);
        check({name, "_ovf"}, overflow, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset              = 1'b1;
        bit_valid          = 1'b0;
        bit_in             = 1'b0;
        ovf_clr            = 1'b0;
        byte_if.data_ready = 1'b0;
        #1 reset = 1'b0;

        // Reset held with random inputs: all outputs stay 0.
        repeat (3) begin
            bit_valid          = 1'($urandom_range(0, 1));
            bit_in             = 1'($urandom_range(0, 1));
            ovf_clr            = 1'($urandom_range(0, 1));
            byte_if.data_ready = 1'($urandom_range(0, 1));
            tick();
            check_all_zero("in_reset");
        end
        bit_valid          = 1'b0;
        bit_in             = 1'b0;
        ovf_clr            = 1'b0;
        byte_if.data_ready = 1'b1;
        reset              = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Basic frame.
        got_q.delete();
        send_byte(8'h00, 0);
        send_byte(SYNC, 0);
        check("basic_locked_after_sync", locked, 1'b1);
        send_payload(8'h11, 0);
        send_payload(8'h22, 0);
        send_payload(8'h33, 0);
        send_payload(8'h44, 0);
        check("basic_unlocked_after_last", locked, 1'b0);
        idle(4);
        check_frame("basic", 4, 64'h11223344, 8'b0001, 8'b0000);

        // Same stream with every other cycle idle.
        got_q.delete();
        send_byte(8'h00, 1);
        send_byte(SYNC, 1);
        send_payload(8'h11, 1);
        send_payload(8'h22, 1);
        send_payload(8'h33, 1);
        send_payload(8'h44, 1);
        idle(4);
        check_frame("gapped", 4, 64'h11223344, 8'b0001, 8'b0000);

        // Backpressure: second frame's first byte overflows and aborts the frame.
        got_q.delete();
        byte_if.data_ready = 1'b0;
        send_byte(SYNC, 0);
        send_payload(8'h11, 0);
        send_payload(8'h22, 0);
        send_payload(8'h33, 0);
        send_payload(8'h44, 0);
        send_byte(SYNC, 0);
        check("bp_locked_second_sync", locked, 1'b1);
        send_payload(8'h55, 0);
        check("bp_overflow_set", overflow, 1'b1);
        check("bp_locked_dropped", locked, 1'b0);
        check("bp_head_held", byte_if.data_out, 8'h11);
        check("bp_model_depth", m_fifo.size(), DEPTH);
        send_payload(8'h66, 0);
        send_payload(8'h77, 0);
        send_payload(8'h88, 0);
        idle(2);
        check("bp_overflow_sticky", overflow, 1'b1);
        check("bp_head_still_held", byte_if.data_out, 8'h11);
        byte_if.data_ready = 1'b1;
        idle(6);
        check_frame("bp", 4, 64'h11223344, 8'b0001, 8'b0000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Full FIFO with push and pop on the same edge: nothing is dropped.
        got_q.delete();
        byte_if.data_ready = 1'b0;
        send_byte(SYNC, 0);
        send_payload(8'h01, 0);
        send_payload(8'h02, 0);
        send_payload(8'h03, 0);
        send_payload(8'h04, 0);
        send_byte(SYNC, 0);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'h99 >> i) & 8'h01), 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit(1'b1, 0);
        byte_if.data_ready = 1'b1;
        send_bit(^(8'h99), 0);
`else
        byte_if.data_ready = 1'b1;
        send_bit(1'b1, 0);
`endif
        check("full_pushpop_no_ovf", overflow, 1'b0);
        check("full_pushpop_locked", locked, 1'b1);
        send_payload(8'h9A, 0);
        send_payload(8'h9B, 0);
        send_payload(8'h9C, 0);
        idle(8);
        check_frame("fullpp", 8, 64'h01020304_999A9B9C, 8'b0001_0001, 8'b0000_0000);

        // Reset in the middle of a frame discards queued bytes.
        got_q.delete();
        byte_if.data_ready = 1'b0;
        send_byte(SYNC, 0);
        send_payload(8'h11, 0);
        send_payload(8'h22, 0);
        check("midrst_queued", byte_if.data_valid, 1'b1);
        reset = 1'b0;
        tick();
        check("midrst_valid", byte_if.data_valid, 1'b0);
        check("midrst_locked", locked, 1'b0);
        reset = 1'b1;
        tick();
        got_q.delete();
        byte_if.data_ready = 1'b1;
        send_byte(SYNC, 0);
        send_payload(8'hC1, 0);
        send_payload(8'hC2, 0);
        send_payload(8'hC3, 0);
        send_payload(8'hC4, 0);
        idle(6);
        check_frame("midrst", 4, 64'hC1C2C3C4, 8'b0001, 8'b0000);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // Parity: 0x11 with bit 0 is good, 0x22 with bit 1 is bad; the frame still completes.
        got_q.delete();
        send_byte(SYNC, 0);
        send_byte(8'h11, 0);
        send_bit(1'b0, 0);
        send_byte(8'h22, 0);
        send_bit(1'b1, 0);
        send_payload(8'h33, 0);
        send_payload(8'h44, 0);
        check("parity_frame_done", locked, 1'b0);
        idle(6);
        check_frame("parity", 4, 64'h11223344, 8'b0001, 8'b0100);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
